// File: rtl/jvm_fetch_pkg.sv
// Shared types for the bytecode prefetch path: fetch FSM states, word size, byte type.
package jvm_fetch_pkg;

  localparam int WORD_BYTES = 4;

  typedef logic [7:0] byte_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/byte_ring_buffer.sv
// Circular byte store: writes 1..4 bytes of a word starting at a skip offset,
// retires a variable number of bytes per cycle, exposes an OUT_BYTES window.
module byte_ring_buffer
  import jvm_fetch_pkg::*;
#(
  parameter int CAP       = 16,
  parameter int OUT_BYTES = 4,
  localparam int PW       = $clog2(CAP),
  localparam int CNTW     = $clog2(CAP + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   wr_en,
  input  logic [31:0]            wr_word,
  input  logic [1:0]             wr_skip,
  input  logic [CNTW-1:0]        rd_adv,
  output logic [8*OUT_BYTES-1:0] window,
  output logic [CNTW-1:0]        occ,
  output logic [CNTW-1:0]        occ_nxt
);

  byte_t           mem_q [CAP];
  byte_t           mem_d [CAP];
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CNTW-1:0] occ_q, occ_d;
  logic [CNTW-1:0] wr_cnt;

  always_comb begin
    wr_cnt = wr_en ? (CNTW'(WORD_BYTES) - CNTW'(wr_skip)) : '0;
    mem_d  = mem_q;
    // Skipped leading bytes are not stored; the kept ones pack from wr_ptr.
    for (int i = 0; i < WORD_BYTES; i++) begin
      if (wr_en && !flush && (i >= int'(wr_skip)))
        mem_d[wr_ptr_q + PW'(i) - PW'(wr_skip)] = wr_word[8*i +: 8];
    end
    if (flush) begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = rd_ptr_q;
      occ_d    = '0;
    end else begin
      rd_ptr_d = rd_ptr_q + PW'(rd_adv);
      wr_ptr_d = wr_ptr_q + PW'(wr_cnt);
      occ_d    = occ_q + wr_cnt - rd_adv;
    end
  end

  always_comb begin
    window = '0;
    for (int j = 0; j < OUT_BYTES; j++)
      window[8*j +: 8] = mem_q[rd_ptr_q + PW'(j)];
  end

  assign occ     = occ_q;
  assign occ_nxt = occ_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < CAP; i++) mem_q[i] <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      occ_q    <= occ_d;
    end
  end

endmodule

// File: rtl/bytecode_prefetch.sv
// Streams instruction words into a byte prefetch buffer and presents a bytecode
// window to the decoder; handles variable consumption and unaligned redirects.
module bytecode_prefetch
  import jvm_fetch_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 8,
  parameter int FIFO_WORDS    = 4,
  parameter int OUT_BYTES     = 4,
  parameter int RESET_PC      = 0
) (
  input  logic                                  clk,
  input  logic                                  reset,
  output logic [ADDRESS_WIDTH-1:0]              mem_address,
  output logic                                  mem_start,
  input  logic [31:0]                           mem_data_in,
  input  logic                                  mem_ready,
  input  logic                                  redirect,
  input  logic [ADDRESS_WIDTH-1:0]              redirect_pc,
  output logic [8*OUT_BYTES-1:0]                window,
  output logic [$clog2(4*FIFO_WORDS+1)-1:0]     byte_count,
  input  logic [$clog2(OUT_BYTES+1)-1:0]        consume,
  output logic [ADDRESS_WIDTH-1:0]              pc
);

  localparam int AW   = ADDRESS_WIDTH;
  localparam int CAP  = WORD_BYTES * FIFO_WORDS;
  localparam int CNTW = $clog2(CAP + 1);
  localparam logic [AW-1:0] RESET_ADDR = AW'(RESET_PC);

  fetch_state_e    state_q, state_d;
  logic [AW-1:0]   pc_q, pc_d;
  logic [AW-1:0]   fetch_addr_q, fetch_addr_d;
  logic [AW-1:0]   target_q, target_d;
  logic [1:0]      skip_q, skip_d;
  logic [CNTW-1:0] occ, occ_nxt, cons_eff;
  logic            wr_en;

  assign wr_en = (state_q == ST_FETCH) && mem_ready && !redirect;

  always_comb begin
    byte_count = (occ > CNTW'(OUT_BYTES)) ? CNTW'(OUT_BYTES) : occ;
    cons_eff   = (CNTW'(consume) > byte_count) ? byte_count : CNTW'(consume);
  end

  byte_ring_buffer #(
    .CAP       (CAP),
    .OUT_BYTES (OUT_BYTES)
  ) u_ring (
    .clk     (clk),
    .rst     (reset),
    .flush   (redirect),
    .wr_en   (wr_en),
    .wr_word (mem_data_in),
    .wr_skip (skip_q),
    .rd_adv  (cons_eff),
    .window  (window),
    .occ     (occ),
    .occ_nxt (occ_nxt)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      pc_q         <= RESET_ADDR;
      fetch_addr_q <= {RESET_ADDR[AW-1:2], 2'b00};
      target_q     <= {RESET_ADDR[AW-1:2], 2'b00};
      skip_q       <= RESET_ADDR[1:0];
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      fetch_addr_q <= fetch_addr_d;
      target_q     <= target_d;
      skip_q       <= skip_d;
    end
  end

  // Room decisions look at next-cycle occupancy so refill starts right after space frees.
  always_comb begin
    state_d = state_q;
    if (redirect) begin
      if ((state_q != ST_IDLE) && !mem_ready) state_d = ST_DRAIN;
      else                                    state_d = ST_FETCH;
    end else begin
      case (state_q)
        ST_IDLE:  if (occ_nxt <= CNTW'(CAP - WORD_BYTES)) state_d = ST_FETCH;
        ST_FETCH: if (mem_ready && (occ_nxt > CNTW'(CAP - WORD_BYTES))) state_d = ST_IDLE;
        ST_DRAIN: if (mem_ready) state_d = ST_FETCH;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    mem_start   = (state_q != ST_IDLE);
    mem_address = fetch_addr_q;
    pc          = pc_q;
  end

  // While draining, the stale address stays on the bus and the new one waits in target.
  always_comb begin
    pc_d         = pc_q + AW'(cons_eff);
    fetch_addr_d = fetch_addr_q;
    target_d     = target_q;
    skip_d       = skip_q;
    if (redirect) begin
      pc_d     = redirect_pc;
      skip_d   = redirect_pc[1:0];
      target_d = {redirect_pc[AW-1:2], 2'b00};
      if (state_d != ST_DRAIN) fetch_addr_d = {redirect_pc[AW-1:2], 2'b00};
    end else if (wr_en) begin
      fetch_addr_d = fetch_addr_q + AW'(WORD_BYTES);
      skip_d       = 2'd0;
    end else if ((state_q == ST_DRAIN) && mem_ready) begin
      fetch_addr_d = target_q;
    end
  end

endmodule

// File: tb/tb_bytecode_prefetch.sv
// Directed plus randomized bench for bytecode_prefetch against a byte-address reference model.
module tb_bytecode_prefetch;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  mem_address;
  logic        mem_start;
  logic [31:0] mem_data_in;
  logic        mem_ready;
  logic        redirect;
  logic [7:0]  redirect_pc;
  logic [31:0] window;
  logic [4:0]  byte_count;
  logic [2:0]  consume;
  logic [7:0]  pc;

  bytecode_prefetch dut (
    .clk         (clk),
    .reset       (reset),
    .mem_address (mem_address),
    .mem_start   (mem_start),
    .mem_data_in (mem_data_in),
    .mem_ready   (mem_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .window      (window),
    .byte_count  (byte_count),
    .consume     (consume),
    .pc          (pc)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem_words [64];
  logic [7:0]  pc_m;
  logic [7:0]  next_m;
  int          occ_m;
  int          skip_m;
  bit          drain_m;
  int          acc_cnt;
  logic [7:0]  acc_addr [$];
  int          rdy_pct;
  bit          force_stall;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] mem_byte(input logic [7:0] a);
    logic [31:0] w;
    w = mem_words[a[7:2]];
    return w[8*int'(a[1:0]) +: 8];
  endfunction

  task automatic check_outputs();
    int          bc;
    logic [31:0] exp_w;
    logic [31:0] mask;
    logic [7:0]  a;
    bc    = (occ_m < 4) ? occ_m : 4;
    exp_w = '0;
    mask  = '0;
    for (int j = 0; j < bc; j++) begin
      a                = pc_m + 8'(j);
      exp_w[8*j +: 8]  = mem_byte(a);
      mask[8*j +: 8]   = 8'hFF;
    end
    chk("pc", 32'(pc), 32'(pc_m));
    chk("byte_count", 32'(byte_count), 32'(bc));
    chk("window", window & mask, exp_w & mask);
    chk("occ_bound", 32'(occ_m <= 16), 32'd1);
    chk("addr_align", 32'(mem_address[1:0]), 32'd0);
  endtask

  // Called just after a falling edge; drives one cycle and checks after the next falling edge.
  task automatic cycle(input int cons, input bit rd, input logic [7:0] rpc);
    logic       st;
    logic [7:0] ad;
    bit         rdy;
    int         c;
    int         bc;
    st  = mem_start;
    ad  = mem_address;
    rdy = st && !force_stall && ($urandom_range(99) < rdy_pct);
    mem_ready   = rdy;
    mem_data_in = rdy ? mem_words[ad[7:2]] : $urandom();
    consume     = 3'(cons);
    redirect    = rd;
    redirect_pc = rpc;
    if (st && !drain_m) chk("fetch_addr", 32'(ad), 32'(next_m));
    @(posedge clk);
    if (rd) begin
      pc_m    = rpc;
      occ_m   = 0;
      next_m  = {rpc[7:2], 2'b00};
      skip_m  = int'(rpc[1:0]);
      drain_m = st && !rdy;
    end else begin
      bc    = (occ_m < 4) ? occ_m : 4;
      c     = (cons < bc) ? cons : bc;
      pc_m  = pc_m + 8'(c);
      occ_m = occ_m - c;
      if (st && rdy) begin
        if (drain_m) drain_m = 1'b0;
        else begin
          occ_m  = occ_m + 4 - skip_m;
          skip_m = 0;
          acc_addr.push_back(ad);
          acc_cnt++;
          next_m = next_m + 8'd4;
        end
      end
    end
    @(negedge clk);
    mem_ready = 1'b0;
    redirect  = 1'b0;
    consume   = '0;
    check_outputs();
  endtask

  task automatic wait_acc(input int target, input string tag);
    for (int k = 0; k < 30 && acc_cnt < target; k++) cycle(0, 1'b0, 8'h00);
    chk(tag, 32'(acc_cnt >= target), 32'd1);
  endtask

  initial begin
    int a0;
    for (int i = 0; i < 64; i++) mem_words[i] = $urandom();
    mem_words[0] = 32'h03020100;
    mem_words[1] = 32'h07060504;
    mem_words[4] = 32'hDDCCBBAA;
    pc_m = 8'h00; next_m = 8'h00; occ_m = 0; skip_m = 0; drain_m = 1'b0; acc_cnt = 0;
    rdy_pct = 100; force_stall = 1'b0;
    reset = 1'b1; mem_ready = 1'b0; mem_data_in = '0; redirect = 1'b0;
    redirect_pc = '0; consume = '0;

    @(negedge clk);
    chk("rst_mem_start", 32'(mem_start), 32'd0);
    chk("rst_mem_address", 32'(mem_address), 32'd0);
    chk("rst_pc", 32'(pc), 32'd0);
    chk("rst_byte_count", 32'(byte_count), 32'd0);
    chk("rst_window", window, 32'd0);
    reset = 1'b0;

    // first two words from reset
    wait_acc(2, "t1_timeout");
    chk("t1_window", window, 32'h03020100);
    chk("t1_byte_count", 32'(byte_count), 32'd4);
    chk("t1_pc", 32'(pc), 32'd0);
    cycle(4, 1'b0, 8'h00);
    chk("t1_window2", window, 32'h07060504);
    chk("t1_pc2", 32'(pc), 32'd4);

    // unaligned redirect
    cycle(0, 1'b1, 8'h11);
    chk("t2_bc_zero", 32'(byte_count), 32'd0);
    chk("t2_pc", 32'(pc), 32'h11);
    wait_acc(acc_cnt + 1, "t2_timeout");
    chk("t2_window", 32'(window[23:0]), 32'h00DDCCBB);
    chk("t2_byte_count", 32'(byte_count), 32'd3);

    // fill with no consumption, then free exactly one word
    cycle(0, 1'b1, 8'h20);
    a0 = acc_cnt;
    repeat (12) cycle(0, 1'b0, 8'h00);
    chk("t3_fetches", 32'(acc_cnt - a0), 32'd4);
    chk("t3_idle", 32'(mem_start), 32'd0);
    repeat (3) cycle(1, 1'b0, 8'h00);
    chk("t3_still_idle", 32'(mem_start), 32'd0);
    cycle(1, 1'b0, 8'h00);
    chk("t3_refill", 32'(mem_start), 32'd1);
    chk("t3_refill_addr", 32'(mem_address), 32'h30);

    // redirect with a request outstanding
    force_stall = 1'b1;
    cycle(0, 1'b1, 8'h40);
    chk("t4_drain_start", 32'(mem_start), 32'd1);
    chk("t4_drain_addr", 32'(mem_address), 32'h30);
    force_stall = 1'b0;
    cycle(0, 1'b0, 8'h00);
    chk("t4_discarded", 32'(byte_count), 32'd0);
    chk("t4_new_addr", 32'(mem_address), 32'h40);
    chk("t4_new_start", 32'(mem_start), 32'd1);
    wait_acc(acc_cnt + 1, "t4_timeout");

    // address wrap
    cycle(0, 1'b1, 8'hFE);
    a0 = acc_cnt;
    wait_acc(a0 + 2, "t5_timeout");
    if (acc_addr.size() >= a0 + 2) begin
      chk("t5_first_fetch", 32'(acc_addr[a0]), 32'hFC);
      chk("t5_second_fetch", 32'(acc_addr[a0 + 1]), 32'h00);
    end
    chk("t5_byte_count", 32'(byte_count), 32'd4);
    cycle(2, 1'b0, 8'h00);
    chk("t5_pc_wrap", 32'(pc), 32'h00);

    // redirect beats same-cycle consume
    cycle(3, 1'b1, 8'h85);
    chk("t6_pc", 32'(pc), 32'h85);
    chk("t6_byte_count", 32'(byte_count), 32'd0);

    // randomized traffic
    for (int n = 0; n < 1500; n++) begin
      if (n % 200 == 0) rdy_pct = $urandom_range(30, 100);
      cycle($urandom_range(0, 4), ($urandom_range(99) < 3), 8'($urandom()));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
